// File: rtl/symbol_upsampler.sv
// Symbol-rate to sample-rate upsampler: 4-deep I/Q FIFO drained one symbol per 2^SPS_LOG2 clocks.
// Optional build macro ZERO_STUFF_EN selects zero insertion instead of sample-and-hold.
module symbol_upsampler #(
  parameter int WIDTH    = 16,
  parameter int SPS_LOG2 = 5,
  parameter int FIFO_AW  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] I_1M,
  input  logic signed [WIDTH-1:0] Q_1M,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [WIDTH-1:0] I_32M,
  output logic signed [WIDTH-1:0] Q_32M,
  output logic                    sample_valid,
  output logic                    sym_strobe,
  output logic                    underflow,
  output logic [FIFO_AW:0]        fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [SPS_LOG2-1:0] LAST_PHASE = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [SPS_LOG2-1:0] phase;

  logic [FIFO_AW:0]        wr_ptr, rd_ptr;
  logic signed [WIDTH-1:0] mem_i [DEPTH];
  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic signed [WIDTH-1:0] head_i, head_q;
  logic                    full, empty, empty_q;
  logic                    push, pop, underflow_next;

  // ---------------------------------------------------------------- FIFO
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign sym_ready  = !full;
  assign push       = sym_valid && !full;
  assign fifo_level = wr_ptr - rd_ptr;
  assign head_i     = mem_i[rd_ptr[FIFO_AW-1:0]];
  assign head_q     = mem_q[rd_ptr[FIFO_AW-1:0]];

  // empty_q delays burst start by one clock so a fresh symbol takes two edges to appear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      empty_q <= empty;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr[FIFO_AW-1:0]] <= I_1M;
      mem_q[wr_ptr[FIFO_AW-1:0]] <= Q_1M;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    pop            = 1'b0;
    underflow_next = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty && !empty_q) begin
          pop        = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (phase == LAST_PHASE) begin
          if (enable && !empty) begin
            pop = 1'b1;
          end else begin
            // Dropping enable is a clean stop; running dry while enabled is an underflow.
            state_next     = IDLE;
            underflow_next = enable;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      I_32M        <= '0;
      Q_32M        <= '0;
      sample_valid <= 1'b0;
      sym_strobe   <= 1'b0;
      underflow    <= 1'b0;
      phase        <= '0;
    end else begin
      sym_strobe   <= pop;
      underflow    <= underflow_next;
      sample_valid <= (state_next == RUN);
      if (pop) begin
        I_32M <= head_i;
        Q_32M <= head_q;
        phase <= '0;
      end else if (state_next == RUN) begin
        phase <= phase + 1'b1;
`ifdef ZERO_STUFF_EN
        I_32M <= '0;
        Q_32M <= '0;
`endif
      end else begin
        I_32M <= '0;
        Q_32M <= '0;
        phase <= '0;
      end
    end
  end

endmodule

// File: tb/tb_symbol_upsampler.sv
// Directed self-checking bench for symbol_upsampler (works in hold and ZERO_STUFF_EN builds).
module tb_symbol_upsampler;

  localparam int SPS = 32;
`ifdef ZERO_STUFF_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, enable, sym_valid;
  logic signed [15:0] I_1M, Q_1M;
  logic               sym_ready, sample_valid, sym_strobe, underflow;
  logic signed [15:0] I_32M, Q_32M;
  logic [2:0]         fifo_level;

  int tests = 0;
  int fails = 0;

  symbol_upsampler dut (
    .clk(clk), .rst(rst), .enable(enable), .I_1M(I_1M), .Q_1M(Q_1M),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .I_32M(I_32M), .Q_32M(Q_32M),
    .sample_valid(sample_valid), .sym_strobe(sym_strobe), .underflow(underflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sample_valid, sym_strobe, underflow, I, Q}
  function automatic logic [34:0] obs();
    return {sample_valid, sym_strobe, underflow, I_32M, Q_32M};
  endfunction

  function automatic logic [15:0] exp_d(input logic [15:0] v, input int n);
    return (!ZS || (n % SPS) == 0) ? v : 16'h0000;
  endfunction

  function automatic logic [34:0] exp_run(input logic [15:0] i, input logic [15:0] q, input int n);
    return {1'b1, (n % SPS) == 0, 1'b0, exp_d(i, n), exp_d(q, n)};
  endfunction

  task automatic push(input logic [15:0] i, input logic [15:0] q);
    sym_valid = 1'b1;
    I_1M = i;
    Q_1M = q;
    step();
    sym_valid = 1'b0;
    I_1M = 16'hDEAD;
    Q_1M = 16'hBEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sym_valid = 1'b0; I_1M = '0; Q_1M = '0;
    step(); step();
    tests++;
    if (obs() !== 35'd0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", obs()); end
    tests++;
    if (fifo_level !== 3'd0 || sym_ready !== 1'b1) begin
      fails++; $display("FAIL reset_fifo level=%0d ready=%b exp level=0 ready=1", fifo_level, sym_ready);
    end
    rst = 1'b0;
    step();
    tests++;
    if (obs() !== 35'd0) begin fails++; $display("FAIL reset_release got=%h exp=0", obs()); end
  endtask

  // Two symbols, then running dry while enabled ends in an underflow pulse.
  task automatic test_hold_and_underflow();
    enable = 1'b1;
    push(16'h1000, 16'hF000);
    push(16'h2000, 16'h0800);
    tests++;
    if (obs() !== 35'd0 || fifo_level !== 3'd2) begin
      fails++; $display("FAIL latency_t1 got=%h level=%0d exp=0 level=2", obs(), fifo_level);
    end
    step();
    for (int n = 0; n < 2 * SPS; n++) begin
      logic [34:0] e;
      e = (n < SPS) ? exp_run(16'h1000, 16'hF000, n) : exp_run(16'h2000, 16'h0800, n);
      tests++;
      if (obs() !== e) begin fails++; $display("FAIL two_sym n=%0d got=%h exp=%h", n, obs(), e); end
      if (n == 0 || n == SPS) begin
        tests++;
        if (fifo_level !== ((n == 0) ? 3'd1 : 3'd0)) begin
          fails++; $display("FAIL two_sym_level n=%0d got=%0d", n, fifo_level);
        end
      end
      step();
    end
    tests++;
    if (obs() !== {3'b001, 32'h0}) begin fails++; $display("FAIL underflow_pulse got=%h exp=%h", obs(), {3'b001, 32'h0}); end
    step();
    tests++;
    if (obs() !== 35'd0) begin fails++; $display("FAIL underflow_once got=%h exp=0", obs()); end
  endtask

  // Fill to full with enable low, then drain four symbols seamlessly.
  task automatic test_back_to_back();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (sym_ready !== (i < 4) || fifo_level !== ((i < 4) ? 3'(i) : 3'd4)) begin
        fails++; $display("FAIL fill i=%0d ready=%b level=%0d", i, sym_ready, fifo_level);
      end
      sym_valid = 1'b1;
      I_1M = 16'h1100 + 16'(i);
      Q_1M = 16'hA000 + 16'(i);
      step();
    end
    sym_valid = 1'b0;
    tests++;
    if (fifo_level !== 3'd4 || sym_ready !== 1'b0) begin
      fails++; $display("FAIL full level=%0d ready=%b exp level=4 ready=0", fifo_level, sym_ready);
    end
    enable = 1'b1;
    step();
    for (int n = 0; n < 4 * SPS; n++) begin
      logic [34:0] e;
      e = exp_run(16'h1100 + 16'(n / SPS), 16'hA000 + 16'(n / SPS), n);
      tests++;
      if (obs() !== e) begin fails++; $display("FAIL b2b n=%0d got=%h exp=%h", n, obs(), e); end
      if (n == 100) enable = 1'b0;
      step();
    end
    tests++;
    if (obs() !== 35'd0 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL b2b_end got=%h level=%0d exp=0 level=0", obs(), fifo_level);
    end
  endtask

  // Enable dropped at phase 10: current symbol completes, two stay queued.
  task automatic test_disable_mid_symbol();
    enable = 1'b0;
    push(16'h0300, 16'hFD00);
    push(16'h0301, 16'hFD01);
    push(16'h0302, 16'hFD02);
    step(); step();
    tests++;
    if (obs() !== 35'd0) begin fails++; $display("FAIL no_start_disabled got=%h exp=0", obs()); end
    enable = 1'b1;
    step();
    for (int n = 0; n < SPS; n++) begin
      logic [34:0] e;
      e = exp_run(16'h0300, 16'hFD00, n);
      tests++;
      if (obs() !== e) begin fails++; $display("FAIL disable n=%0d got=%h exp=%h", n, obs(), e); end
      if (n == 10) enable = 1'b0;
      step();
    end
    tests++;
    if (obs() !== 35'd0 || fifo_level !== 3'd2) begin
      fails++; $display("FAIL disable_end got=%h level=%0d exp=0 level=2", obs(), fifo_level);
    end
    step(); step();
    tests++;
    if (obs() !== 35'd0) begin fails++; $display("FAIL disable_idle got=%h exp=0", obs()); end
  endtask

  // Reset mid-burst at phase 17 with three queued symbols flushes everything.
  task automatic test_reset_mid_burst();
    int bad;
    push(16'h0303, 16'hFD03);
    push(16'h0304, 16'hFD04);
    tests++;
    if (fifo_level !== 3'd4) begin fails++; $display("FAIL pre_rst_level got=%0d exp=4", fifo_level); end
    enable = 1'b1;
    step();
    for (int n = 0; n < 17; n++) step();
    tests++;
    if (obs() !== exp_run(16'h0301, 16'hFD01, 17) || fifo_level !== 3'd3) begin
      fails++; $display("FAIL phase17 got=%h level=%0d exp=%h level=3", obs(), fifo_level,
                        exp_run(16'h0301, 16'hFD01, 17));
    end
    rst = 1'b1;
    step();
    tests++;
    if (obs() !== 35'd0 || fifo_level !== 3'd0 || sym_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset got=%h level=%0d ready=%b exp=0 level=0 ready=1",
                        obs(), fifo_level, sym_ready);
    end
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (sample_valid !== 1'b0 || fifo_level !== 3'd0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL post_reset_quiet bad_cycles=%0d exp=0", bad); end
    push(16'h0404, 16'h0505);
    step();
    tests++;
    if (obs() !== 35'd0) begin fails++; $display("FAIL post_reset_t1 got=%h exp=0", obs()); end
    step();
    tests++;
    if (obs() !== exp_run(16'h0404, 16'h0505, 0)) begin
      fails++; $display("FAIL post_reset_sym got=%h exp=%h", obs(), exp_run(16'h0404, 16'h0505, 0));
    end
    enable = 1'b0;
    for (int n = 0; n < SPS + 2; n++) step();
  endtask

  // Extreme values: zeros after the strobe in the zero-stuff build, held otherwise.
  task automatic test_zero_stuff();
    enable = 1'b1;
    push(16'h7FFF, 16'h8000);
    step();
    step();
    for (int n = 0; n < SPS; n++) begin
      logic [34:0] e;
      e = exp_run(16'h7FFF, 16'h8000, n);
      tests++;
      if (obs() !== e) begin fails++; $display("FAIL zstuff n=%0d got=%h exp=%h", n, obs(), e); end
      step();
    end
    tests++;
    if (obs() !== {3'b001, 32'h0}) begin fails++; $display("FAIL zstuff_underflow got=%h", obs()); end
  endtask

  initial begin
    test_reset();
    test_hold_and_underflow();
    test_back_to_back();
    test_disable_mid_symbol();
    test_reset_mid_burst();
    test_zero_stuff();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
